// File: rtl/branch_seq_pkg.sv
// Shared definitions for the conditional-branch sequencer: state encoding, opcodes
// and the state-to-strobe decode used by branch_seq.
package branch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CON  = 3'd1,
    S_PC   = 3'd2,
    S_ADD  = 3'd3,
    S_LD   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [4:0] BR_OPCODE = 5'b10010;
  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_ADD    = 5'b00011;

  typedef struct packed {
    logic       Gra;
    logic       Rout;
    logic       CONin;
    logic       PCout;
    logic       Yin;
    logic       Cout;
    logic [4:0] alu_op;
    logic       Zin;
    logic       Zlowout;
    logic       PCin;
    logic       busy;
    logic       done;
  } strobes_t;

  // PC is only reloaded in S_LD when the latched condition says the branch is taken.
  function automatic strobes_t decode_strobes(state_t s, logic tk);
    strobes_t o;
    o        = '0;
    o.alu_op = OP_NOP;
    o.busy   = (s != S_IDLE);
    case (s)
      S_CON: begin
        o.Gra   = 1'b1;
        o.Rout  = 1'b1;
        o.CONin = 1'b1;
      end
      S_PC: begin
        o.PCout = 1'b1;
        o.Yin   = 1'b1;
      end
      S_ADD: begin
        o.Cout   = 1'b1;
        o.Zin    = 1'b1;
        o.alu_op = OP_ADD;
      end
      S_LD: begin
        o.Zlowout = 1'b1;
        o.PCin    = tk;
      end
      S_DONE: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Handshake and datapath-strobe bundle between main control, branch_seq and the datapath.
interface branch_seq_if;
  logic        start;
  logic [31:0] IR;
  logic        con_in;
  logic        Gra;
  logic        Rout;
  logic        CONin;
  logic        PCout;
  logic        Yin;
  logic        Cout;
  logic [4:0]  alu_op;
  logic        Zin;
  logic        Zlowout;
  logic        PCin;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;

  modport master (
    output start, IR, con_in,
    input  Gra, Rout, CONin, PCout, Yin, Cout, alu_op, Zin, Zlowout, PCin,
           busy, done, taken, illegal
  );

  modport slave (
    input  start, IR, con_in,
    output Gra, Rout, CONin, PCout, Yin, Cout, alu_op, Zin, Zlowout, PCin,
           busy, done, taken, illegal
  );
endinterface

// File: rtl/branch_seq.sv
// Execute-phase sequencer for brzr/brnz/brpl/brmi. Define BRANCH_SKIP_EN to let a
// not-taken branch jump from S_PC straight to S_DONE (3-cycle latency instead of 5).
module branch_seq
  import branch_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  branch_seq_if.slave bus
);

  state_t   state;
  state_t   nxt;
  logic     taken_q;
  logic     taken_nxt;
  logic     illegal_q;
  logic     illegal_nxt;
  strobes_t strb;

  // Only the opcode field matters here; the rest of IR feeds the datapath directly.
  logic unused_ir;
  assign unused_ir = ^bus.IR[26:0];

  always_comb begin
    nxt         = state;
    taken_nxt   = taken_q;
    illegal_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.IR[31:27] == BR_OPCODE) begin
            nxt       = S_CON;
            taken_nxt = 1'b0;
          end else begin
            illegal_nxt = 1'b1;
          end
        end
      end
      S_CON: nxt = S_PC;
      S_PC: begin
        // CON was enabled a full cycle earlier, so con_in is settled here.
        taken_nxt = bus.con_in;
`ifdef BRANCH_SKIP_EN
        nxt = bus.con_in ? S_ADD : S_DONE;
`else
        nxt = S_ADD;
`endif
      end
      S_ADD:   nxt = S_LD;
      S_LD:    nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      strb      <= '0;
    end else begin
      state     <= nxt;
      taken_q   <= taken_nxt;
      illegal_q <= illegal_nxt;
      strb      <= decode_strobes(nxt, taken_nxt);
    end
  end

  assign bus.Gra     = strb.Gra;
  assign bus.Rout    = strb.Rout;
  assign bus.CONin   = strb.CONin;
  assign bus.PCout   = strb.PCout;
  assign bus.Yin     = strb.Yin;
  assign bus.Cout    = strb.Cout;
  assign bus.alu_op  = strb.alu_op;
  assign bus.Zin     = strb.Zin;
  assign bus.Zlowout = strb.Zlowout;
  assign bus.PCin    = strb.PCin;
  assign bus.busy    = strb.busy;
  assign bus.done    = strb.done;
  assign bus.taken   = taken_q;
  assign bus.illegal = illegal_q;

endmodule
